// File: rtl/uart_cmd_responder_if.sv
// Command/response bus between the UART pair and uart_cmd_responder.
// The responder uses the slave modport; the driving side uses master.
interface uart_cmd_responder_if #(
  parameter int W_OUT = 16
);
  logic             rx_valid;
  logic [W_OUT-1:0] rx_data;
  logic             tx_valid;
  logic [W_OUT-1:0] tx_data;
  logic             tx_ready;
  logic             overflow;

  modport master (
    output rx_valid, rx_data, tx_ready,
    input  tx_valid, tx_data, overflow
  );

  modport slave (
    input  rx_valid, rx_data, tx_ready,
    output tx_valid, tx_data, overflow
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// UART command endpoint: FIFO-buffered opcode/argument words run against a small
// register file, one response per command. Define UART_CMD_WRITE_ACK_EN to ack SET_ADDR/WRITE.
module uart_cmd_responder #(
  parameter int BITS_PER_WORD = 8,
  parameter int W_OUT         = 16,
  parameter int NUM_REGS      = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  uart_cmd_responder_if.slave  bus
);
  localparam int ARG_W = W_OUT - BITS_PER_WORD;
  localparam int AW    = $clog2(NUM_REGS);
  localparam int FW    = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  localparam logic [BITS_PER_WORD-1:0] OP_SET_ADDR = BITS_PER_WORD'(8'h10);
  localparam logic [BITS_PER_WORD-1:0] OP_WRITE    = BITS_PER_WORD'(8'h20);
  localparam logic [BITS_PER_WORD-1:0] OP_READ     = BITS_PER_WORD'(8'h30);
  localparam logic [BITS_PER_WORD-1:0] OP_ECHO     = BITS_PER_WORD'(8'h40);
  localparam logic [BITS_PER_WORD-1:0] OP_STATUS   = BITS_PER_WORD'(8'h50);
  localparam logic [BITS_PER_WORD-1:0] OP_ERR      = BITS_PER_WORD'(8'hEE);

  localparam logic [FW:0]    PTR_ONE  = (FW+1)'(1);
  localparam logic [AW-1:0]  ADDR_ONE = AW'(1);

`ifdef UART_CMD_WRITE_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic [1:0]         state;
  logic [W_OUT-1:0]   cmd;
  logic [AW-1:0]      addr;
  logic [ARG_W-1:0]   regs [NUM_REGS];
  logic               tx_valid_q;
  logic [W_OUT-1:0]   tx_data_q;
  logic               overflow_q;

  // Input stage: registering the receiver word sets the k+3 response latency.
  logic               rx_stb;
  logic [W_OUT-1:0]   rx_word;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // always_ff samples the pre-edge values of the others regardless of evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_stb  <= 1'b0;
      rx_word <= '0;
    end else begin
      rx_stb  <= bus.rx_valid;
      rx_word <= bus.rx_data;
    end
  end

  logic [W_OUT-1:0] fifo_mem [FIFO_DEPTH];
  logic [FW:0]      wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, pop, push, drop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign push       = rx_stb && (!fifo_full || pop);
  assign drop       = rx_stb && fifo_full && !pop;

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[FW-1:0]] <= rx_word;
  end

  logic [BITS_PER_WORD-1:0] op;
  logic [ARG_W-1:0]         arg;
  logic [BITS_PER_WORD-1:0] resp_op;
  logic [ARG_W-1:0]         resp_arg;
  logic [ARG_W-1:0]         status_arg;
  logic                     respond, set_addr, wr_en, inc_addr, clr_ovf;

  assign op  = cmd[W_OUT-1:ARG_W];
  assign arg = cmd[ARG_W-1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    status_arg           = '0;
    status_arg[AW-1:0]   = addr;
    status_arg[ARG_W-1]  = overflow_q;
    resp_op  = op;
    resp_arg = arg;
    respond  = 1'b1;
    set_addr = 1'b0;
    wr_en    = 1'b0;
    inc_addr = 1'b0;
    clr_ovf  = 1'b0;
    case (op)
      OP_SET_ADDR: begin
        set_addr = 1'b1;
        respond  = ACK_EN;
      end
      OP_WRITE: begin
        wr_en    = 1'b1;
        inc_addr = 1'b1;
        respond  = ACK_EN;
      end
      OP_READ: begin
        resp_arg = regs[addr];
        inc_addr = 1'b1;
      end
      OP_ECHO: ;
      OP_STATUS: begin
        resp_arg = status_arg;
        clr_ovf  = 1'b1;
      end
      default: begin
        resp_op  = OP_ERR;
        resp_arg = ARG_W'(op);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      // A drop in the STATUS cycle wins over the clear.
      if (drop)                              overflow_q <= 1'b1;
      else if (state == S_EXEC && clr_ovf)   overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      cmd        <= '0;
      addr       <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cmd   <= fifo_mem[rd_ptr[FW-1:0]];
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (set_addr)      addr <= arg[AW-1:0];
          else if (inc_addr) addr <= addr + ADDR_ONE;
          if (wr_en)         regs[addr] <= arg;
          if (respond) begin
            tx_data_q  <= {resp_op, resp_arg};
            tx_valid_q <= 1'b1;
            state      <= S_SEND;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SEND: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.overflow = overflow_q;
endmodule
